strand_sequencer: RTL and testbench



---
 rtl/hydra_pkg.sv | 44 ++++
 rtl/strand_cfg_regfile.sv | 33 +++
 rtl/strand_sequencer.sv | 179 +++++++++++++++++
 tb/tb_strand_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hydra_pkg.sv
// Shared types and constants for the strand sequencer slice.
// Optional feature macro: HYDRA_SEQ_REVERSE_EN (per-strand reverse scan).
package hydra_pkg;

    localparam int STRAND_PARAM_WIDTH = 16;
    localparam int NUM_STRANDS        = 8;
    localparam int STRAND_SEL_WIDTH   = $clog2(NUM_STRANDS);

    typedef logic [STRAND_PARAM_WIDTH-1:0] sparam_t;

    // Largest length that keeps start + cnt inside the bus width.
    localparam sparam_t LEN_MAX =
        sparam_t'(1) << (STRAND_PARAM_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    typedef struct packed {
        sparam_t offset;
        sparam_t length;
        sparam_t start;
        logic    reverse;
    } strand_cfg_t;

    // Saturate the length, then drop a rotation that lands outside it.
    function automatic strand_cfg_t cfg_sanitize(
        input sparam_t offset,
        input sparam_t length,
        input sparam_t start,
        input logic    reverse
    );
        strand_cfg_t c;
        c.offset  = offset;
        c.length  = (length > LEN_MAX) ? LEN_MAX : length;
        c.start   = (start >= c.length) ? '0 : start;
        c.reverse = reverse;
        return c;
    endfunction

endpackage

// File: rtl/strand_cfg_regfile.sv
// Per-strand configuration store: one write port, one async read port.
// Entries clear to zero on reset.
module strand_cfg_regfile
    import hydra_pkg::*;
#(
    parameter int ENTRIES = hydra_pkg::NUM_STRANDS,
    parameter int SEL_W   = hydra_pkg::STRAND_SEL_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [SEL_W-1:0]  waddr_i,
    input  strand_cfg_t       wdata_i,
    input  logic [SEL_W-1:0]  raddr_i,
    output strand_cfg_t       rdata_o
);

    strand_cfg_t mem_q [ENTRIES];

    // Storage array, written only when the sequencer is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/strand_sequencer.sv
// Walks every pixel of every configured strand once per frame.
// Optional macro HYDRA_SEQ_REVERSE_EN adds cfg_reverse and descending scans.
module strand_sequencer
    import hydra_pkg::*;
#(
    parameter int NUM_STRANDS        = hydra_pkg::NUM_STRANDS,
    parameter int STRAND_SEL_WIDTH   = hydra_pkg::STRAND_SEL_WIDTH,
    parameter int STRAND_PARAM_WIDTH = hydra_pkg::STRAND_PARAM_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_we,
    input  logic [STRAND_SEL_WIDTH-1:0]   cfg_strand,
    input  logic [STRAND_PARAM_WIDTH-1:0] cfg_offset,
    input  logic [STRAND_PARAM_WIDTH-1:0] cfg_length,
    input  logic [STRAND_PARAM_WIDTH-1:0] cfg_start,
`ifdef HYDRA_SEQ_REVERSE_EN
    input  logic                          cfg_reverse,
`endif
    output logic                          cfg_ack,
    input  logic                          frame_start,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [STRAND_SEL_WIDTH-1:0]   strand_sel,
    output logic [STRAND_PARAM_WIDTH-1:0] strand_offset,
    output logic [STRAND_PARAM_WIDTH-1:0] strand_idx,
    output logic [STRAND_PARAM_WIDTH-1:0] strand_length
);

    localparam logic [STRAND_PARAM_WIDTH-1:0] ONE =
        STRAND_PARAM_WIDTH'(1);
    localparam logic [STRAND_SEL_WIDTH-1:0] SEL_ONE =
        STRAND_SEL_WIDTH'(1);
    localparam logic [STRAND_SEL_WIDTH-1:0] SEL_LAST =
        STRAND_SEL_WIDTH'(NUM_STRANDS - 1);

    seq_state_t state_q, state_d;

    logic [STRAND_SEL_WIDTH-1:0]   sel_q, sel_d;
    logic [STRAND_PARAM_WIDTH-1:0] cnt_q, cnt_d;
    logic [STRAND_PARAM_WIDTH-1:0] idx_q, idx_d;
    logic [STRAND_PARAM_WIDTH-1:0] off_q, off_d;
    logic [STRAND_PARAM_WIDTH-1:0] len_q, len_d;
    logic                          rev_q, rev_d;
    logic                          valid_q, valid_d;
    logic                          ack_q, ack_d;

    logic        cfg_wr;
    logic        wr_rev;
    strand_cfg_t wr_cfg;
    strand_cfg_t rd_cfg;

`ifdef HYDRA_SEQ_REVERSE_EN
    assign wr_rev = cfg_reverse;
`else
    assign wr_rev = 1'b0;
`endif

    assign cfg_wr = cfg_we && (state_q == ST_IDLE);
    assign wr_cfg = cfg_sanitize(cfg_offset, cfg_length,
                                 cfg_start, wr_rev);

    strand_cfg_regfile #(
        .ENTRIES (NUM_STRANDS),
        .SEL_W   (STRAND_SEL_WIDTH)
    ) u_cfg (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (cfg_wr),
        .waddr_i (cfg_strand),
        .wdata_i (wr_cfg),
        .raddr_i (sel_q),
        .rdata_o (rd_cfg)
    );

    // State and registered output bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            len_q   <= '0;
            rev_q   <= 1'b0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            len_q   <= len_d;
            rev_q   <= rev_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
        end
    end

    // Scan sequencing: strand load, pixel stepping, frame end.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        len_d   = len_q;
        rev_d   = rev_q;
        valid_d = valid_q;
        ack_d   = cfg_wr;

        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_LOAD;
                    sel_d   = '0;
                end
            end
            ST_LOAD: begin
                off_d = rd_cfg.offset;
                len_d = rd_cfg.length;
                rev_d = rd_cfg.reverse;
                cnt_d = '0;
                if (rd_cfg.length == '0) begin
                    if (sel_q == SEL_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        sel_d = sel_q + SEL_ONE;
                    end
                end else begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    if (rd_cfg.reverse) begin
                        idx_d = rd_cfg.start
                              + rd_cfg.length - ONE;
                    end else begin
                        idx_d = rd_cfg.start;
                    end
                end
            end
            ST_RUN: begin
                if (valid_q && out_ready) begin
                    if (cnt_q == len_q - ONE) begin
                        valid_d = 1'b0;
                        if (sel_q == SEL_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_LOAD;
                            sel_d   = sel_q + SEL_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE;
                        idx_d = rev_q ? (idx_q - ONE)
                                      : (idx_q + ONE);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cfg_ack       = ack_q;
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = (state_q == ST_DONE);
    assign out_valid     = valid_q;
    assign strand_sel    = sel_q;
    assign strand_offset = off_q;
    assign strand_idx    = idx_q;
    assign strand_length = len_q;

endmodule

// File: tb/tb_strand_sequencer.sv
// Self-checking bench for strand_sequencer: table vectors, random frames
// against a pixel-list model, and hand-written reset/saturation sequences.
module tb_strand_sequencer;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_strand;
    logic [15:0] cfg_offset;
    logic [15:0] cfg_length;
    logic [15:0] cfg_start;
    logic        cfg_reverse;
    logic        cfg_ack;
    logic        frame_start;
    logic        busy;
    logic        frame_done;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  strand_sel;
    logic [15:0] strand_offset;
    logic [15:0] strand_idx;
    logic [15:0] strand_length;

    int errors = 0;
    int checks = 0;

    strand_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_we        (cfg_we),
        .cfg_strand    (cfg_strand),
        .cfg_offset    (cfg_offset),
        .cfg_length    (cfg_length),
        .cfg_start     (cfg_start),
`ifdef HYDRA_SEQ_REVERSE_EN
        .cfg_reverse   (cfg_reverse),
`endif
        .cfg_ack       (cfg_ack),
        .frame_start   (frame_start),
        .busy          (busy),
        .frame_done    (frame_done),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .strand_sel    (strand_sel),
        .strand_offset (strand_offset),
        .strand_idx    (strand_idx),
        .strand_length (strand_length)
    );

    always #5 clk = ~clk;

    // Reference configuration as the spec says it must be stored.
    typedef struct {
        logic [15:0] off;
        logic [15:0] len;
        logic [15:0] start;
        bit          rev;
    } mcfg_t;

    typedef struct {
        int          sel;
        logic [15:0] off;
        logic [15:0] idx;
        logic [15:0] len;
        int          gap;
    } txn_t;

    typedef struct {
        int          s;
        logic [15:0] off;
        logic [15:0] len;
        logic [15:0] start;
        bit          rev;
        logic [15:0] exp_len;
        logic [15:0] exp_start;
    } vec_t;

    mcfg_t mcfg [N];
    vec_t  tbl  [N];

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    function automatic logic [51:0] bus_now();
        return {out_valid, strand_sel, strand_offset,
                strand_idx, strand_length};
    endfunction

    function automatic logic [51:0] pk(input int sel,
                                       input logic [15:0] off,
                                       input logic [15:0] idx,
                                       input logic [15:0] len);
        return {1'b1, 3'(sel), off, idx, len};
    endfunction

    function automatic mcfg_t ref_store(input int off, input int len,
                                        input int start, input bit rev);
        mcfg_t m;
        int l;
        int s;
        l = (len > 32768) ? 32768 : len;
        s = (start >= l) ? 0 : start;
        m.off   = 16'(off);
        m.len   = 16'(l);
        m.start = 16'(s);
        m.rev   = rev;
        return m;
    endfunction

    task automatic write_cfg(input int s, input logic [15:0] off,
                             input logic [15:0] len,
                             input logic [15:0] start,
                             input bit rev);
        @(negedge clk);
        cfg_we      = 1'b1;
        cfg_strand  = 3'(s);
        cfg_offset  = off;
        cfg_length  = len;
        cfg_start   = start;
        cfg_reverse = rev;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("cfg_ack", cfg_ack, 1);
    endtask

    // One frame: expected pixel list built from mcfg, then compared
    // handshake by handshake, with stall-hold and timing checks.
    task automatic run_frame(input bit rnd_ready, input bit poke);
        txn_t        q[$];
        txn_t        t;
        int          zeros;
        int          last_nz;
        int          exp_done;
        int          cyc;
        int          rise;
        int          v;
        bit          prev_v;
        bit          held;
        bit          done_seen;
        bit          rdy;
        logic [51:0] hbus;

        zeros   = 0;
        last_nz = -1;
        for (int s = 0; s < N; s++) begin
            if (mcfg[s].len == 0) begin
                zeros++;
            end else begin
                for (int c = 0; c < int'(mcfg[s].len); c++) begin
                    if (mcfg[s].rev)
                        v = mcfg[s].start + mcfg[s].len - 1 - c;
                    else
                        v = mcfg[s].start + c;
                    t.sel = s;
                    t.off = mcfg[s].off;
                    t.idx = v[15:0];
                    t.len = mcfg[s].len;
                    t.gap = (c == 0) ? zeros + 2 : 0;
                    q.push_back(t);
                end
                zeros   = 0;
                last_nz = s;
            end
        end
        exp_done = N - last_nz;

        @(negedge clk);
        frame_start = 1'b1;
        out_ready   = 1'b1;
        cyc       = 0;
        rise      = 0;
        prev_v    = 1'b0;
        held      = 1'b0;
        done_seen = 1'b0;
        hbus      = '0;

        for (int k = 0; k < 3000 && !done_seen; k++) begin
            @(negedge clk);
            frame_start = 1'b0;
            cfg_we      = 1'b0;
            cyc++;
            if (held) chk("hold", bus_now(), hbus);
            chk("ack_busy", cfg_ack, 0);
            if (out_valid && !prev_v) rise = cyc;
            prev_v = out_valid;
            if (frame_done) begin
                chk("done_gap", cyc, exp_done);
                chk("done_all_px", q.size(), 0);
                done_seen = 1'b1;
            end else begin
                chk("busy", busy, 1);
                rdy = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
                out_ready = rdy;
                if (out_valid && rdy) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_px: got %0h expected none",
                                 bus_now());
                    end else begin
                        t = q.pop_front();
                        chk("px", bus_now(),
                            pk(t.sel, t.off, t.idx, t.len));
                        if (t.gap != 0) chk("first_gap", rise, t.gap);
                    end
                    cyc = 0;
                end
                held = out_valid && !rdy;
                hbus = bus_now();
                if (poke && ($urandom_range(0, 1) == 1)) begin
                    cfg_we      = 1'b1;
                    cfg_strand  = 3'($urandom_range(0, N - 1));
                    cfg_offset  = 16'($urandom);
                    cfg_length  = 16'($urandom_range(0, 9));
                    cfg_start   = 16'($urandom_range(0, 9));
                    cfg_reverse = 1'($urandom_range(0, 1));
                    frame_start = 1'($urandom_range(0, 1));
                end
            end
        end

        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no frame_done, %0d px left",
                     q.size());
        end
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("done_pulse", frame_done, 0);
        out_ready = 1'b1;
    endtask

    initial begin
        bit rv;

        tbl[0] = '{0, 16'd100,  16'd4,  16'd0, 1'b0, 16'd4, 16'd0};
        tbl[1] = '{1, 16'd0,    16'd5,  16'd3, 1'b0, 16'd5, 16'd3};
        tbl[2] = '{2, 16'd200,  16'd4,  16'd9, 1'b0, 16'd4, 16'd0};
        tbl[3] = '{3, 16'd7,    16'd0,  16'd0, 1'b0, 16'd0, 16'd0};
        tbl[4] = '{4, 16'd50,   16'd1,  16'd0, 1'b0, 16'd1, 16'd0};
        tbl[5] = '{5, 16'h300,  16'd3,  16'd3, 1'b0, 16'd3, 16'd0};
        tbl[6] = '{6, 16'd11,   16'd0,  16'd5, 1'b0, 16'd0, 16'd0};
        tbl[7] = '{7, 16'd9,    16'd2,  16'd1, 1'b0, 16'd2, 16'd1};

        rst_n       = 1'b0;
        cfg_we      = 1'b0;
        cfg_strand  = '0;
        cfg_offset  = '0;
        cfg_length  = '0;
        cfg_start   = '0;
        cfg_reverse = 1'b0;
        frame_start = 1'b0;
        out_ready   = 1'b1;
        #1;
        chk("reset_out", {bus_now(), busy, frame_done, cfg_ack}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) begin
            write_cfg(tbl[i].s, tbl[i].off, tbl[i].len,
                      tbl[i].start, tbl[i].rev);
            mcfg[tbl[i].s] = '{tbl[i].off, tbl[i].exp_len,
                               tbl[i].exp_start, tbl[i].rev};
        end
        @(negedge clk);
        chk("ack_pulse_end", cfg_ack, 0);

        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);
        run_frame(1'b1, 1'b1);
        run_frame(1'b0, 1'b0);

        for (int f = 0; f < 6; f++) begin
            for (int s = 0; s < N; s++) begin
                int l;
                int st;
                int o;
                l  = $urandom_range(0, 7);
                st = $urandom_range(0, 9);
                o  = $urandom_range(0, 65535);
`ifdef HYDRA_SEQ_REVERSE_EN
                rv = 1'($urandom_range(0, 1));
`else
                rv = 1'b0;
`endif
                write_cfg(s, 16'(o), 16'(l), 16'(st), rv);
                mcfg[s] = ref_store(o, l, st, rv);
            end
            run_frame(1'b1, f[0]);
        end

        // Saturated length, then reset in the middle of the run.
        write_cfg(0, 16'h1234, 16'hFFFF, 16'h7FFF, 1'b0);
        @(negedge clk);
        frame_start = 1'b1;
        out_ready   = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        chk("sat_first", bus_now(),
            pk(0, 16'h1234, 16'h7FFF, 16'h8000));
        repeat (3) @(negedge clk);
        chk("sat_step", bus_now(),
            pk(0, 16'h1234, 16'h8002, 16'h8000));
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out", {bus_now(), busy, frame_done, cfg_ack}, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            chk("abort_nodone", frame_done, 0);
        end
        for (int s = 0; s < N; s++) mcfg[s] = '{16'd0, 16'd0, 16'd0, 1'b0};
        run_frame(1'b0, 1'b0);

`ifdef HYDRA_SEQ_REVERSE_EN
        write_cfg(0, 16'd10, 16'd4, 16'd1, 1'b1);
        mcfg[0] = '{16'd10, 16'd4, 16'd1, 1'b1};
        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
